// File: rtl/mem_stage_pkg.sv
// Shared widths, opcodes and FSM encoding for the memory stage and its data memory.
// Opcode helpers keep load/store decoding in one place.
package mem_stage_pkg;

  localparam int REG_WIDTH    = 32;
  localparam int PC_WIDTH     = 32;
  localparam int IR_WIDTH     = 32;
  localparam int OPCODE_WIDTH = 8;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D = 8'h01;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDB   = 8'h20;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW   = 8'h21;
  localparam logic [OPCODE_WIDTH-1:0] OP_STB   = 8'h22;
  localparam logic [OPCODE_WIDTH-1:0] OP_STW   = 8'h23;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  function automatic logic is_load(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_LDB) || (op == OP_LDW);
  endfunction

  function automatic logic is_store(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_STB) || (op == OP_STW);
  endfunction

  function automatic logic [3:0] byte_strobe(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  // Little-endian lane select, zero-extended to register width.
  function automatic logic [REG_WIDTH-1:0] lane_byte(input logic [31:0] word,
                                                     input logic [1:0]  lane);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    return {{(REG_WIDTH-8){1'b0}}, shifted[7:0]};
  endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Byte-addressable word memory: asynchronous read, per-lane write strobes on negedge.
// Contents are never reset; they are only ever changed through the strobes.
module data_mem #(
  parameter int WORDS  = 1024,
  parameter int ADDR_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [WORDS];

  assign rdata = mem[addr];

  always_ff @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage between Execute and Writeback: LDB/LDW/STB/STW against a local data
// memory with MEM_LATENCY wait cycles, producing the MEM latch and the upstream stall.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_WORDS  = 1024,
  parameter int MEM_LATENCY = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET,
  input  logic                    I_LOCK,
  input  logic [PC_WIDTH-1:0]     I_PC,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [IR_WIDTH-1:0]     I_IR,
  input  logic [3:0]              I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]    I_DestValue,
  input  logic [2:0]              I_CCValue,
  input  logic [REG_WIDTH-1:0]    I_MARValue,
  input  logic [REG_WIDTH-1:0]    I_MDRValue,
  input  logic                    I_EX_Valid,
  input  logic                    I_RegWEn,
  input  logic                    I_CCWEn,
  output logic                    O_LOCK,
  output logic [PC_WIDTH-1:0]     O_PC,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [IR_WIDTH-1:0]     O_IR,
  output logic [3:0]              O_DestRegIdx,
  output logic [REG_WIDTH-1:0]    O_DestValue,
  output logic [2:0]              O_CCValue,
  output logic                    O_MEM_Valid,
  output logic                    O_RegWEn,
  output logic                    O_CCWEn,
  output logic                    O_RegWEn_Signal,
  output logic                    O_MEMStall_Signal,
  output logic                    O_MemState
);

  localparam int ADDR_W = $clog2(DMEM_WORDS);
  localparam bit HAS_WAIT = (MEM_LATENCY > 0);
  localparam logic [CNT_WIDTH-1:0] WAIT_INIT =
    CNT_WIDTH'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

  mem_state_e           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 load_op, store_op, mem_op;
  logic                 access_now, take;
  logic [ADDR_W-1:0]    idx;
  logic [3:0]           wstrb;
  logic [31:0]          wdata, rdata;
  logic [REG_WIDTH-1:0] load_data;
  logic                 unused_mar;

  assign load_op  = is_load(I_Opcode);
  assign store_op = is_store(I_Opcode);
  assign mem_op   = I_LOCK & I_EX_Valid & (load_op | store_op);

  // The access happens on exactly one edge per instruction: the IDLE edge when there
  // are no wait states, otherwise the WAIT edge where the counter has reached zero.
  assign access_now = mem_op & (((state == MEM_IDLE) & !HAS_WAIT) |
                                ((state == MEM_WAIT) & (cnt == '0)));

  // MEM latch is written on this edge (any non-memory op, or a completing access).
  assign take = I_LOCK & (((state == MEM_IDLE) & !(mem_op & HAS_WAIT)) |
                          ((state == MEM_WAIT) & mem_op & (cnt == '0)));

  assign O_MEMStall_Signal = I_LOCK & (((state == MEM_IDLE) & mem_op & HAS_WAIT) |
                                       ((state == MEM_WAIT) & (cnt != '0)));
  assign O_RegWEn_Signal   = I_EX_Valid & I_RegWEn;
  assign O_MemState        = (state == MEM_WAIT);

  assign idx        = I_MARValue[ADDR_W+1:2];
  assign unused_mar = ^I_MARValue[REG_WIDTH-1:ADDR_W+2];

  assign wstrb = (access_now & store_op & !I_RESET)
               ? ((I_Opcode == OP_STW) ? 4'hF : byte_strobe(I_MARValue[1:0]))
               : 4'h0;
  assign wdata = (I_Opcode == OP_STW) ? I_MDRValue : {4{I_MDRValue[7:0]}};
  assign load_data = (I_Opcode == OP_LDW) ? rdata : lane_byte(rdata, I_MARValue[1:0]);

  data_mem #(
    .WORDS (DMEM_WORDS),
    .ADDR_W(ADDR_W)
  ) u_dmem (
    .clk  (I_CLOCK),
    .addr (idx),
    .wstrb(wstrb),
    .wdata(wdata),
    .rdata(rdata)
  );

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      state        <= MEM_IDLE;
      cnt          <= '0;
      O_LOCK       <= 1'b0;
      O_PC         <= '0;
      O_Opcode     <= '0;
      O_IR         <= '0;
      O_DestRegIdx <= '0;
      O_DestValue  <= '0;
      O_CCValue    <= '0;
      O_MEM_Valid  <= 1'b0;
      O_RegWEn     <= 1'b0;
      O_CCWEn      <= 1'b0;
    end else begin
      O_LOCK      <= I_LOCK;
      O_MEM_Valid <= take & I_EX_Valid;
      O_RegWEn    <= take & I_EX_Valid & !store_op & I_RegWEn;
      O_CCWEn     <= take & I_EX_Valid & !store_op & I_CCWEn;
      if (take) begin
        O_PC         <= I_PC;
        O_Opcode     <= I_Opcode;
        O_IR         <= I_IR;
        O_DestRegIdx <= I_DestRegIdx;
        O_DestValue  <= (load_op & I_EX_Valid) ? load_data : I_DestValue;
        O_CCValue    <= I_CCValue;
      end

      if (!I_LOCK) begin
        state <= MEM_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          MEM_IDLE: begin
            if (mem_op && HAS_WAIT) begin
              state <= MEM_WAIT;
              cnt   <= WAIT_INIT;
            end
          end
          MEM_WAIT: begin
            if (!mem_op || cnt == '0) begin
              state <= MEM_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= MEM_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: u_fast (no wait states) and u_slow (two wait states)
// share data inputs and reset but have their own lock/valid.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk, rst;
  logic lock0, lock1, valid0, valid1;
  logic [PC_WIDTH-1:0]     pc;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [IR_WIDTH-1:0]     ir;
  logic [3:0]              dest_idx;
  logic [REG_WIDTH-1:0]    dest_val, mar, mdr;
  logic [2:0]              cc;
  logic                    reg_wen, cc_wen;

  logic                    o_lock0, o_lock1;
  logic [PC_WIDTH-1:0]     o_pc0, o_pc1;
  logic [OPCODE_WIDTH-1:0] o_opcode0, o_opcode1;
  logic [IR_WIDTH-1:0]     o_ir0, o_ir1;
  logic [3:0]              o_dest_idx0, o_dest_idx1;
  logic [REG_WIDTH-1:0]    o_dest_val0, o_dest_val1;
  logic [2:0]              o_cc0, o_cc1;
  logic                    o_valid0, o_valid1, o_reg_wen0, o_reg_wen1;
  logic                    o_cc_wen0, o_cc_wen1, o_sig0, o_sig1;
  logic                    o_stall0, o_stall1, o_state0, o_state1;

  int checks = 0;
  int errors = 0;
  logic [PC_WIDTH-1:0] held_pc;

  mem_stage #(.DMEM_WORDS(1024), .MEM_LATENCY(0), .CNT_WIDTH(4)) u_fast (
    .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock0), .I_PC(pc), .I_Opcode(opcode),
    .I_IR(ir), .I_DestRegIdx(dest_idx), .I_DestValue(dest_val), .I_CCValue(cc),
    .I_MARValue(mar), .I_MDRValue(mdr), .I_EX_Valid(valid0), .I_RegWEn(reg_wen),
    .I_CCWEn(cc_wen), .O_LOCK(o_lock0), .O_PC(o_pc0), .O_Opcode(o_opcode0),
    .O_IR(o_ir0), .O_DestRegIdx(o_dest_idx0), .O_DestValue(o_dest_val0),
    .O_CCValue(o_cc0), .O_MEM_Valid(o_valid0), .O_RegWEn(o_reg_wen0),
    .O_CCWEn(o_cc_wen0), .O_RegWEn_Signal(o_sig0), .O_MEMStall_Signal(o_stall0),
    .O_MemState(o_state0)
  );

  mem_stage #(.DMEM_WORDS(1024), .MEM_LATENCY(2), .CNT_WIDTH(4)) u_slow (
    .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock1), .I_PC(pc), .I_Opcode(opcode),
    .I_IR(ir), .I_DestRegIdx(dest_idx), .I_DestValue(dest_val), .I_CCValue(cc),
    .I_MARValue(mar), .I_MDRValue(mdr), .I_EX_Valid(valid1), .I_RegWEn(reg_wen),
    .I_CCWEn(cc_wen), .O_LOCK(o_lock1), .O_PC(o_pc1), .O_Opcode(o_opcode1),
    .O_IR(o_ir1), .O_DestRegIdx(o_dest_idx1), .O_DestValue(o_dest_val1),
    .O_CCValue(o_cc1), .O_MEM_Valid(o_valid1), .O_RegWEn(o_reg_wen1),
    .O_CCWEn(o_cc_wen1), .O_RegWEn_Signal(o_sig1), .O_MEMStall_Signal(o_stall1),
    .O_MemState(o_state1)
  );

  // Clock/reset: state updates on negedge, bench drives and samples at posedge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] dv, input logic rw, input logic cw);
    pc       = pc + 32'd4;
    opcode   = op;
    ir       = {op, pc[23:0]};
    dest_idx = pc[5:2];
    dest_val = dv;
    mar      = a;
    mdr      = d;
    reg_wen  = rw;
    cc_wen   = cw;
    cc       = 3'b010;
  endtask

  // One access on u_slow: stall for two cycles with bubbles, result on the third edge.
  task automatic run_slow(input string tag, input logic is_ld, input logic [31:0] exp);
    valid1 = 1'b1;
    #1 chk({tag, "_stall_e0"}, 32'(o_stall1), 32'd1);
    cycle();
    chk({tag, "_valid_e1"}, 32'(o_valid1), 32'd0);
    chk({tag, "_stall_e1"}, 32'(o_stall1), 32'd1);
    chk({tag, "_state_e1"}, 32'(o_state1), 32'd1);
    cycle();
    chk({tag, "_valid_e2"}, 32'(o_valid1), 32'd0);
    chk({tag, "_stall_e2"}, 32'(o_stall1), 32'd0);
    cycle();
    chk({tag, "_valid_e3"}, 32'(o_valid1), 32'd1);
    chk({tag, "_state_e3"}, 32'(o_state1), 32'd0);
    if (is_ld) chk({tag, "_data"}, o_dest_val1, exp);
    else       chk({tag, "_regwen"}, 32'(o_reg_wen1), 32'd0);
    valid1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lock0 = 1'b1; lock1 = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
    pc = '0; opcode = '0; ir = '0; dest_idx = '0; dest_val = '0;
    mar = '0; mdr = '0; cc = '0; reg_wen = 1'b0; cc_wen = 1'b0;
    cycle();
    cycle();
    chk("rst_valid0", 32'(o_valid0), 32'd0);
    chk("rst_lock0", 32'(o_lock0), 32'd0);
    chk("rst_dval0", o_dest_val0, 32'd0);
    chk("rst_pc1", o_pc1, 32'd0);
    chk("rst_stall1", 32'(o_stall1), 32'd0);
    chk("rst_state1", 32'(o_state1), 32'd0);
    rst = 1'b0;

    // Single-cycle path
    drive(OP_STW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    valid0 = 1'b1;
    #1 chk("stw_nostall", 32'(o_stall0), 32'd0);
    cycle();
    chk("stw_valid", 32'(o_valid0), 32'd1);
    chk("stw_regwen", 32'(o_reg_wen0), 32'd0);
    chk("stw_lock", 32'(o_lock0), 32'd1);
    chk("stw_pc", o_pc0, pc);
    drive(OP_LDW, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    chk("ldw_data", o_dest_val0, 32'hDEADBEEF);
    chk("ldw_valid", 32'(o_valid0), 32'd1);
    chk("ldw_regwen", 32'(o_reg_wen0), 32'd1);

    // Byte store/load, truncation and address wrap
    drive(OP_STW, 32'h10, 32'h11223344, 32'h0, 1'b0, 1'b0);
    cycle();
    drive(OP_STB, 32'h12, 32'h000000AA, 32'h0, 1'b1, 1'b1);
    cycle();
    chk("stb_regwen", 32'(o_reg_wen0), 32'd0);
    chk("stb_ccwen", 32'(o_cc_wen0), 32'd0);
    drive(OP_LDW, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    chk("stb_word", o_dest_val0, 32'h11AA3344);
    drive(OP_LDB, 32'h12, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    chk("ldb_lane2", o_dest_val0, 32'h000000AA);
    drive(OP_LDB, 32'h13, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    chk("ldb_lane3", o_dest_val0, 32'h00000011);
    drive(OP_LDB, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    chk("ldb_lane0", o_dest_val0, 32'h00000044);
    drive(OP_LDW, 32'h13, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    chk("ldw_unaligned", o_dest_val0, 32'h11AA3344);
    drive(OP_LDW, 32'h1010, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    chk("ldw_wrap", o_dest_val0, 32'h11AA3344);

    // Pass-through and dependency signal
    drive(OP_ADD_D, 32'h10, 32'h55, 32'hFFFFFFFD, 1'b1, 1'b1);
    cc = 3'b100;
    #1 chk("add_sig", 32'(o_sig0), 32'd1);
    chk("add_nostall", 32'(o_stall0), 32'd0);
    cycle();
    chk("add_dval", o_dest_val0, 32'hFFFFFFFD);
    chk("add_cc", 32'(o_cc0), 32'h4);
    chk("add_regwen", 32'(o_reg_wen0), 32'd1);
    chk("add_ccwen", 32'(o_cc_wen0), 32'd1);
    chk("add_valid", 32'(o_valid0), 32'd1);
    chk("add_opcode", 32'(o_opcode0), 32'(OP_ADD_D));
    chk("add_ir", o_ir0, ir);
    chk("add_idx", 32'(o_dest_idx0), 32'(dest_idx));

    // Invalid instruction: no write, no valid
    drive(OP_STW, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
    held_pc = pc;
    valid0 = 1'b0;
    #1 chk("inv_sig", 32'(o_sig0), 32'd0);
    cycle();
    chk("inv_valid", 32'(o_valid0), 32'd0);
    chk("inv_regwen", 32'(o_reg_wen0), 32'd0);

    // Lock low with a valid store
    drive(OP_STW, 32'h10, 32'h55, 32'h0, 1'b0, 1'b0);
    valid0 = 1'b1;
    lock0 = 1'b0;
    cycle();
    chk("lock_olock", 32'(o_lock0), 32'd0);
    chk("lock_valid", 32'(o_valid0), 32'd0);
    chk("lock_pc_hold", o_pc0, held_pc);
    lock0 = 1'b1;
    drive(OP_LDW, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    chk("nowrite_word", o_dest_val0, 32'h11AA3344);
    valid0 = 1'b0;

    // Wait states
    drive(OP_STW, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    run_slow("slow_stw", 1'b0, 32'h0);
    drive(OP_LDW, 32'h8, 32'h0, 32'h0, 1'b1, 1'b0);
    run_slow("slow_ldw", 1'b1, 32'hCAFEF00D);

    // Reset on the edge that would commit the store
    drive(OP_STW, 32'h20, 32'h77, 32'h0, 1'b0, 1'b0);
    run_slow("slow_init", 1'b0, 32'h0);
    drive(OP_STW, 32'h20, 32'h5, 32'h0, 1'b0, 1'b0);
    valid1 = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    valid1 = 1'b0;
    #1 chk("abort_stall", 32'(o_stall1), 32'd0);
    chk("abort_state", 32'(o_state1), 32'd0);
    chk("abort_valid", 32'(o_valid1), 32'd0);
    chk("abort_lock", 32'(o_lock1), 32'd0);
    chk("abort_pc", o_pc1, 32'd0);
    chk("abort_dval", o_dest_val1, 32'd0);
    @(posedge clk);
    drive(OP_LDW, 32'h20, 32'h0, 32'h0, 1'b1, 1'b0);
    run_slow("abort_mem", 1'b1, 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the GPU-frame pipeline, sitting between Execute and Writeback.
- Consumes the EX output latch (opcode, IR, PC, dest idx/value, CC, MAR/MDR, valid, write enables).
- Performs LDB/LDW/STB/STW against an internal byte-addressed data memory with a configurable wait-state count, and produces the MEM output latch for Writeback.
- Drives a stall signal to the upstream stages and a combinational reg-write-enable to DE for dependency checking.

Parameters:
- DMEM_WORDS, 1024, number of 32-bit words in data memory; address index is MAR[log2(DMEM_WORDS)+1:2].
- MEM_LATENCY, 2, extra wait cycles per load/store; 0 means single-cycle access.
- CNT_WIDTH, 4, wait counter width; must satisfy MEM_LATENCY < 2**CNT_WIDTH.

Ports:
- I_CLOCK  in  1  stage clock; all state updates on negedge I_CLOCK, consistent with the other stages.
- I_RESET  in  1  synchronous, active-high reset, sampled on negedge I_CLOCK.
- I_LOCK  in  1  pipeline lock; 0 inserts a bubble.
- I_PC  in  `PC_WIDTH  instruction PC.
- I_Opcode  in  `OPCODE_WIDTH  decoded opcode.
- I_IR  in  `IR_WIDTH  instruction word.
- I_DestRegIdx  in  4  destination scalar register.
- I_DestValue  in  `REG_WIDTH  ALU result.
- I_CCValue  in  3  CC {N,Z,P}.
- I_MARValue  in  `REG_WIDTH  byte address.
- I_MDRValue  in  `REG_WIDTH  store data.
- I_EX_Valid  in  1  EX latch holds a valid instruction.
- I_RegWEn  in  1  register write enable.
- I_CCWEn  in  1  CC write enable.
- O_LOCK  out  1  registered I_LOCK.
- O_PC  out  `PC_WIDTH  registered PC.
- O_Opcode  out  `OPCODE_WIDTH  registered opcode.
- O_IR  out  `IR_WIDTH  registered IR.
- O_DestRegIdx  out  4  registered destination register.
- O_DestValue  out  `REG_WIDTH  load data for loads, else I_DestValue.
- O_CCValue  out  3  registered CC.
- O_MEM_Valid  out  1  MEM latch holds a valid instruction.
- O_RegWEn  out  1  registered register write enable.
- O_CCWEn  out  1  registered CC write enable.
- O_RegWEn_Signal  out  1  combinational: I_EX_Valid & I_RegWEn, to DE.
- O_MEMStall_Signal  out  1  combinational: high while an access is in progress; upstream holds the EX latch.

Behaviour:
- Reset: all O_* registers 0; FSM to IDLE; counter 0. Memory contents are not cleared; they are initialised only by the bench/loader.
- Memory op: mem_op = I_LOCK & I_EX_Valid & opcode in {LDB, LDW, STB, STW}.
- FSM, IDLE state:
  - If mem_op and MEM_LATENCY > 0: enter WAIT, counter = MEM_LATENCY-1, stall = 1, emit a bubble.
  - Otherwise: latch inputs this edge (single-cycle path; loads/stores are performed this edge).
- FSM, WAIT state:
  - stall = 1; bubble emitted each cycle.
  - When counter == 0, the access completes on that edge: store commits, load data latched, MEM latch written with a valid result, return to IDLE, stall drops.
  - Otherwise, decrement the counter.
- Latency: MEM_LATENCY+1 cycles EX->MEM for memory ops; 1 cycle for all others.
- Bubble: O_MEM_Valid = O_RegWEn = O_CCWEn = 0; other O_* hold their previous values.
- I_LOCK = 0: O_LOCK = 0; bubble; FSM stays in or returns to IDLE.
- LDW: data = mem[idx]; MAR[1:0] ignored (word aligned by truncation).
- LDB: byte lane MAR[1:0], little-endian (lane 0 = bits 7:0), zero-extended to `REG_WIDTH.
- Load write enables: RegWEn = I_RegWEn; CC passes through unchanged.
- STW: mem[idx] = MDR.
- STB: MDR[7:0] is written to lane MAR[1:0]; the other lanes are preserved.
- Store write enables: O_RegWEn = 0, O_CCWEn = 0.
- Each store is written exactly once per instruction.
- Invalid instructions (I_EX_Valid = 0) never touch memory.
- Reset during WAIT: abort; no store is committed; IDLE next cycle.
- Out-of-range MAR: upper bits are ignored (address wraps modulo memory size).
- Non-memory ops while the FSM is in WAIT cannot occur, because upstream is stalled; inputs are assumed stable while stall = 1.

Decomposition:
- Package global_def.h: `REG_WIDTH, `PC_WIDTH, `IR_WIDTH, `OPCODE_WIDTH, the `OP_LD*/`OP_ST* opcodes, and FSM state encodings MEM_IDLE/MEM_WAIT.
- Sub-module data_mem: word array with read port and byte-lane write strobes (4-bit wstrb), written on negedge.

Test Plan:
- Single-cycle path, MEM_LATENCY=0:
  - STW MAR=0x10, MDR=0xDEADBEEF, then LDW MAR=0x10 -> O_DestValue = 0xDEADBEEF, O_MEM_Valid = 1, one cycle after each.
- Byte store/load:
  - STB MAR=0x12, MDR=0x000000AA onto word 0x11223344 -> word = 0x11AA3344.
  - LDB MAR=0x12 -> O_DestValue = 0x000000AA.
- Wait states, MEM_LATENCY=2:
  - LDW -> O_MEMStall_Signal high for exactly 2 cycles, 2 bubbles, then a valid result on the 3rd edge.
- Reset mid-WAIT:
  - STW MAR=0x20, MDR=5 with I_RESET pulsed during WAIT -> mem[0x20] unchanged, all outputs 0, stall low the next cycle.
- Pass-through and dependency signal:
  - ADD_D, I_DestValue = -3, I_RegWEn = 1, I_CCValue = 3'b100 -> values pass through in 1 cycle, no stall.
  - O_RegWEn_Signal = 1 combinationally.
  - With I_EX_Valid = 0 -> O_MEM_Valid = 0 and no memory write.
- Lock low:
  - I_LOCK = 0 with a valid STW -> no write, O_LOCK = 0, O_MEM_Valid = 0.
